// File: rtl/time_tag_decoder.sv
// -----------------------------------------------------------------------------
// time_tag_decoder
//
// Purpose:
//   This block turns a stream of frontend time-tag words into absolute
//   timestamps. There are two kinds of input word:
//     - Rollover words carry the current period count. The block keeps it in
//       period_reg.
//     - Event words carry a COUNTER-bit coarse counter. The block joins it
//       with period_reg to form {period, counter}.
//   The block starts UNSYNC, and it discards events until it sees a rollover.
//   Each event discarded while unsynced is counted in drop_count, which
//   saturates at 0xFFFF.
//
// Configuration:
//   TIME_TAG_CHECK_EN (macro) -- when defined, a rollover accepted in SYNC is
//   checked against period_reg+1. On a discontinuity seq_err pulses for one
//   cycle. When the macro is undefined, seq_err is tied low and no comparator
//   is built.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   input word present
//   in_ready   out  input word accepted when in_valid && in_ready
//   in_type    in   0 = event word, 1 = rollover word
//   in_data    in   rollover: period; event: counter in [COUNTER-1:0]
//   desync     in   request to drop sync on the next edge
//   out_valid  out  decoded timestamp present
//   out_ready  in   downstream accepts out_time
//   out_time   out  {period, counter} absolute timestamp
//   synced     out  high in SYNC
//   drop_count out  events discarded while unsynced (saturating)
//   seq_err    out  one-cycle pulse on a period discontinuity
// -----------------------------------------------------------------------------
module time_tag_decoder #(
  parameter int COUNTER  = 19,
  parameter int PERIOD_W = 48
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_type,
  input  logic [PERIOD_W-1:0]         in_data,
  input  logic                        desync,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PERIOD_W+COUNTER-1:0] out_time,
  output logic                        synced,
  output logic [15:0]                 drop_count,
  output logic                        seq_err
);

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } state_t;

  state_t                      state_reg;
  logic [PERIOD_W-1:0]         period_reg;
  logic                        out_valid_reg;
  logic [PERIOD_W+COUNTER-1:0] out_time_reg;
  logic [15:0]                 drop_count_reg;
  logic                        accept;

  // Back-pressure depends only on the output stage. This lets a draining
  // output and a new event share the same edge (accept-and-replace).
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  assign out_valid  = out_valid_reg;
  assign out_time   = out_time_reg;
  assign synced     = (state_reg == SYNC);
  assign drop_count = drop_count_reg;

`ifdef TIME_TAG_CHECK_EN
  logic                seq_err_reg;
  logic [PERIOD_W-1:0] period_inc;

  // The increment is width-limited, so max period + 1 wraps to 0 as expected.
  assign period_inc = period_reg + {{(PERIOD_W-1){1'b0}}, 1'b1};
  assign seq_err    = seq_err_reg;
`else
  assign seq_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= UNSYNC;
      period_reg     <= '0;
      out_valid_reg  <= 1'b0;
      out_time_reg   <= '0;
      drop_count_reg <= '0;
`ifdef TIME_TAG_CHECK_EN
      seq_err_reg    <= 1'b0;
`endif
    end else begin
`ifdef TIME_TAG_CHECK_EN
      seq_err_reg <= 1'b0;
`endif
      // The downstream took the current timestamp. A new event later in this
      // block overrides this clear, which gives accept-and-replace.
      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end

      if (desync) begin
        // desync wins over a rollover in the same cycle, and that rollover is
        // lost. An event in the same cycle is counted as dropped. A pending
        // output is kept.
        state_reg <= UNSYNC;
        if (accept && !in_type && (drop_count_reg != 16'hFFFF)) begin
          drop_count_reg <= drop_count_reg + 16'd1;
        end
      end else if (accept) begin
        case (state_reg)
          UNSYNC: begin
            if (in_type) begin
              period_reg <= in_data;
              state_reg  <= SYNC;
            end else if (drop_count_reg != 16'hFFFF) begin
              drop_count_reg <= drop_count_reg + 16'd1;
            end
          end
          SYNC: begin
            if (in_type) begin
              period_reg <= in_data;
`ifdef TIME_TAG_CHECK_EN
              seq_err_reg <= (in_data != period_inc);
`endif
            end else begin
              out_time_reg  <= {period_reg, in_data[COUNTER-1:0]};
              out_valid_reg <= 1'b1;
            end
          end
          default: state_reg <= UNSYNC;
        endcase
      end
    end
  end

endmodule
